// File: rtl/barrier_controller_pkg.sv
// Shared types for the barrier controller slot table.
// Masks are stored at full warp-mask width; the top slices to NUM_WARPS.
package barrier_types;

  localparam int BARRIER_ID_W = 16;
  localparam int BLOCK_ID_W   = 10;
  localparam int WARP_MASK_W  = 32;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } slot_state_e;

  typedef struct packed {
    slot_state_e             state;
    logic [BARRIER_ID_W-1:0] barrier_id;
    logic [BLOCK_ID_W-1:0]   block_id;
    logic [WARP_MASK_W-1:0]  expected;
    logic [WARP_MASK_W-1:0]  arrived;
  } barrier_slot_t;

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: index of the lowest set bit, plus an any-set flag.
module lowest_set_idx #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/barrier_controller.sv
// Barrier synchronisation unit: tracks warp arrivals per (block, barrier)
// in a slot table, presents parked warps as stall and issues releases.
module barrier_controller
  import barrier_types::*;
#(
  parameter int NUM_WARPS = 32,
  parameter int NUM_SLOTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BARRIER_ID_W-1:0] barrier_id,
  input  logic [BLOCK_ID_W-1:0]   block_id,
  input  logic [5:0]              warp_id,
  input  logic [31:0]             thread_mask,
  input  logic [NUM_WARPS-1:0]    expected_mask,
  input  logic                    request_valid,
  output logic                    ready,
  output logic [BARRIER_ID_W-1:0] release_barrier_id,
  output logic [BLOCK_ID_W-1:0]   release_block_id,
  output logic [NUM_WARPS-1:0]    release_warp_mask,
  output logic                    release_valid,
  input  logic                    release_ready,
  output logic                    stall,
  output logic [NUM_WARPS-1:0]    stall_warp_mask,
  output logic                    protocol_err
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  barrier_slot_t slot_q [NUM_SLOTS];
  barrier_slot_t slot_d [NUM_SLOTS];

  logic [NUM_SLOTS-1:0]   free_vec;
  logic [NUM_SLOTS-1:0]   done_vec;
  logic [NUM_SLOTS-1:0]   hit_vec;
  logic [SLOT_W-1:0]      free_idx;
  logic [SLOT_W-1:0]      done_idx;
  logic [SLOT_W-1:0]      hit_idx;
  logic                   any_free;
  logic                   any_done;
  logic                   hit;
  logic                   accept;
  logic                   rel_fire;
  logic                   warp_ok;
  logic                   err_d;
  logic                   err_q;
  logic [WARP_MASK_W-1:0] warp_bit;
  logic [WARP_MASK_W-1:0] exp_in;
  logic [WARP_MASK_W-1:0] hit_arrived;
  logic [WARP_MASK_W-1:0] stall_acc;
  logic                   unused_thread;

  // Thread activity does not affect barrier accounting.
  assign unused_thread = ^thread_mask;

  assign warp_ok  = int'(warp_id) < NUM_WARPS;
  assign warp_bit = warp_ok ? (WARP_MASK_W'(1) << warp_id) : '0;

  always_comb begin
    exp_in = '0;
    exp_in[NUM_WARPS-1:0] = expected_mask;
  end

  always_comb begin
    free_vec  = '0;
    done_vec  = '0;
    hit_vec   = '0;
    stall_acc = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      free_vec[s] = slot_q[s].state == FREE;
      done_vec[s] = slot_q[s].state == DONE;
      hit_vec[s]  = (slot_q[s].state == COLLECT) &&
                    (slot_q[s].barrier_id == barrier_id) &&
                    (slot_q[s].block_id == block_id);
      if (slot_q[s].state != FREE) stall_acc = stall_acc | slot_q[s].arrived;
    end
  end

  lowest_set_idx #(.N(NUM_SLOTS), .IDX_W(SLOT_W)) u_free (
    .mask (free_vec),
    .idx  (free_idx),
    .any  (any_free)
  );

  lowest_set_idx #(.N(NUM_SLOTS), .IDX_W(SLOT_W)) u_done (
    .mask (done_vec),
    .idx  (done_idx),
    .any  (any_done)
  );

  lowest_set_idx #(.N(NUM_SLOTS), .IDX_W(SLOT_W)) u_hit (
    .mask (hit_vec),
    .idx  (hit_idx),
    .any  (hit)
  );

  assign ready    = hit | any_free;
  assign accept   = request_valid & ready;
  assign rel_fire = any_done & release_ready;

  // Hit, free and done slots are always distinct, so the writes never collide.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) slot_d[s] = slot_q[s];
    err_d       = 1'b0;
    hit_arrived = slot_q[hit_idx].arrived | warp_bit;
    if (accept) begin
      unique case (1'b1)
        !warp_ok: err_d = 1'b1;
        warp_ok && hit: begin
          if (((slot_q[hit_idx].arrived & warp_bit) != '0) ||
              ((slot_q[hit_idx].expected & warp_bit) == '0)) begin
            err_d = 1'b1;
          end else begin
            slot_d[hit_idx].arrived = hit_arrived;
            if (hit_arrived == slot_q[hit_idx].expected)
              slot_d[hit_idx].state = DONE;
          end
        end
        warp_ok && !hit: begin
          if ((exp_in & warp_bit) == '0) begin
            err_d = 1'b1;
          end else begin
            slot_d[free_idx].state      = (warp_bit == exp_in) ? DONE : COLLECT;
            slot_d[free_idx].barrier_id = barrier_id;
            slot_d[free_idx].block_id   = block_id;
            slot_d[free_idx].expected   = exp_in;
            slot_d[free_idx].arrived    = warp_bit;
          end
        end
      endcase
    end
    if (rel_fire) begin
      slot_d[done_idx].state   = FREE;
      slot_d[done_idx].arrived = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) slot_q[s] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) slot_q[s] <= slot_d[s];
      err_q <= err_d;
    end
  end

  assign release_valid      = any_done;
  assign release_barrier_id = any_done ? slot_q[done_idx].barrier_id : '0;
  assign release_block_id   = any_done ? slot_q[done_idx].block_id : '0;
  assign release_warp_mask  =
    any_done ? slot_q[done_idx].arrived[NUM_WARPS-1:0] : '0;
  assign stall_warp_mask    = stall_acc[NUM_WARPS-1:0];
  assign stall              = |stall_warp_mask;
  assign protocol_err       = err_q;

endmodule

// File: tb/tb_barrier_controller.sv
// Directed and randomized checks of barrier_controller against a table model.
module tb_barrier_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] barrier_id = '0;
  logic [9:0]  block_id = '0;
  logic [5:0]  warp_id = '0;
  logic [31:0] thread_mask = '0;
  logic [31:0] expected_mask = '0;
  logic        request_valid = 1'b0;
  logic        ready;
  logic [15:0] release_barrier_id;
  logic [9:0]  release_block_id;
  logic [31:0] release_warp_mask;
  logic        release_valid;
  logic        release_ready = 1'b0;
  logic        stall;
  logic [31:0] stall_warp_mask;
  logic        protocol_err;

  int n_assert = 0;
  int n_fail = 0;

  // Model: open barriers with their slot position, key and masks.
  bit          m_val [4];
  bit          m_done [4];
  logic [15:0] m_bid [4];
  logic [9:0]  m_blk [4];
  logic [31:0] m_exp [4];
  logic [31:0] m_arr [4];
  bit          m_err;

  always #5 clk = ~clk;

  barrier_controller #(.NUM_WARPS(32), .NUM_SLOTS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .barrier_id         (barrier_id),
    .block_id           (block_id),
    .warp_id            (warp_id),
    .thread_mask        (thread_mask),
    .expected_mask      (expected_mask),
    .request_valid      (request_valid),
    .ready              (ready),
    .release_barrier_id (release_barrier_id),
    .release_block_id   (release_block_id),
    .release_warp_mask  (release_warp_mask),
    .release_valid      (release_valid),
    .release_ready      (release_ready),
    .stall              (stall),
    .stall_warp_mask    (stall_warp_mask),
    .protocol_err       (protocol_err)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 0; m_done[i] = 0; m_bid[i] = '0;
      m_blk[i] = '0; m_exp[i] = '0; m_arr[i] = '0;
    end
    m_err = 0;
  endtask

  task automatic do_reset();
    request_valid = 1'b0;
    release_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_rvalid"}, release_valid, 0);
    chk({tag, "_rbid"}, release_barrier_id, 0);
    chk({tag, "_rblk"}, release_block_id, 0);
    chk({tag, "_rmask"}, release_warp_mask, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_smask"}, stall_warp_mask, 0);
    chk({tag, "_perr"}, protocol_err, 0);
  endtask

  // One clock: drive, compare outputs with the model, advance the model.
  task automatic cycle(bit rv, logic [15:0] bid, logic [9:0] blk,
                       logic [5:0] wid, logic [31:0] exp, bit rr);
    bit e_ready, e_rv;
    logic [15:0] e_bid;
    logic [9:0]  e_blk;
    logic [31:0] e_mask, e_stall;
    int h, f, r;
    request_valid = rv; barrier_id = bid; block_id = blk;
    warp_id = wid; expected_mask = exp; release_ready = rr;
    thread_mask = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
    #1;
    e_ready = 0; e_rv = 0; e_bid = '0; e_blk = '0; e_mask = '0; e_stall = '0;
    h = -1; f = -1; r = -1;
    for (int i = 0; i < 4; i++) begin
      if (m_val[i]) e_stall |= m_arr[i];
      if (m_val[i] && !m_done[i] && m_bid[i] == bid && m_blk[i] == blk) h = i;
      if (!m_val[i] && f < 0) f = i;
      if (m_val[i] && m_done[i] && r < 0) r = i;
    end
    e_ready = (h >= 0) || (f >= 0);
    if (r >= 0) begin
      e_rv = 1; e_bid = m_bid[r]; e_blk = m_blk[r]; e_mask = m_arr[r];
    end
    chk("ready", ready, e_ready);
    chk("release_valid", release_valid, e_rv);
    chk("release_barrier_id", release_barrier_id, e_bid);
    chk("release_block_id", release_block_id, e_blk);
    chk("release_warp_mask", release_warp_mask, e_mask);
    chk("stall_warp_mask", stall_warp_mask, e_stall);
    chk("stall", stall, e_stall != 0);
    chk("protocol_err", protocol_err, m_err);
    m_err = 0;
    if (rv && e_ready) begin
      if (wid >= 32) m_err = 1;
      else if (h >= 0) begin
        if (m_arr[h][wid] || !m_exp[h][wid]) m_err = 1;
        else begin
          m_arr[h][wid] = 1'b1;
          if (m_arr[h] == m_exp[h]) m_done[h] = 1;
        end
      end else if (!exp[wid]) m_err = 1;
      else begin
        m_val[f] = 1; m_bid[f] = bid; m_blk[f] = blk; m_exp[f] = exp;
        m_arr[f] = 32'h1 << wid;
        m_done[f] = (m_arr[f] == exp);
      end
    end
    if (rr && r >= 0) m_val[r] = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] key_exp [3];
    key_exp[0] = 32'h0000_000F;
    key_exp[1] = 32'h0000_0033;
    key_exp[2] = 32'h0000_0001;

    do_reset();
    chk_reset("reset");

    // Basic collection and release.
    cycle(1, 7, 3, 0, 32'hF, 0);
    cycle(1, 7, 3, 1, 32'hF, 0);
    cycle(1, 7, 3, 2, 32'hF, 0);
    chk("t1_stall", stall_warp_mask, 32'h7);
    chk("t1_norel", release_valid, 0);
    cycle(1, 7, 3, 3, 32'hF, 0);
    chk("t1_rvalid", release_valid, 1);
    chk("t1_rmask", release_warp_mask, 32'hF);
    chk("t1_rblk", release_block_id, 3);
    chk("t1_rbid", release_barrier_id, 7);
    cycle(0, 0, 0, 0, 0, 1);
    chk("t1_stall_clr", stall_warp_mask, 0);

    // Table full: held request waits for a release.
    do_reset();
    cycle(1, 10, 1, 0, 32'h3, 0);
    cycle(1, 11, 1, 0, 32'h3, 0);
    cycle(1, 12, 1, 0, 32'h3, 0);
    cycle(1, 13, 1, 0, 32'h1, 0);
    cycle(1, 14, 1, 0, 32'h3, 0);
    cycle(1, 14, 1, 0, 32'h3, 0);
    chk("t2_ready_full", ready, 0);
    cycle(1, 14, 1, 0, 32'h3, 1);
    chk("t2_ready_free", ready, 1);
    cycle(1, 14, 1, 0, 32'h3, 0);
    chk("t2_rvalid", release_valid, 0);

    // Two DONE slots: lowest index held stable, then the next.
    do_reset();
    cycle(1, 20, 2, 0, 32'h3, 0);
    cycle(1, 21, 2, 0, 32'h3, 0);
    cycle(1, 22, 2, 0, 32'h3, 0);
    cycle(1, 21, 2, 1, 32'h3, 0);
    cycle(1, 22, 2, 1, 32'h3, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_bid", release_barrier_id, 21);
      cycle(0, 0, 0, 0, 0, 0);
    end
    cycle(0, 0, 0, 0, 0, 1);
    chk("t3_next_bid", release_barrier_id, 22);

    // Duplicate and not-expected arrivals are dropped.
    do_reset();
    cycle(1, 30, 4, 2, 32'hFF, 0);
    cycle(1, 30, 4, 2, 32'hFF, 0);
    chk("t4_dup_err", protocol_err, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t4_err_pulse", protocol_err, 0);
    chk("t4_arrived", stall_warp_mask, 32'h4);
    cycle(1, 31, 4, 5, 32'h3, 0);
    chk("t4_nexp_err", protocol_err, 1);
    chk("t4_noalloc", stall_warp_mask, 32'h4);
    cycle(1, 30, 4, 40, 32'hFF, 0);
    chk("t4_range_err", protocol_err, 1);

    // Arrival matching a held DONE slot opens a new generation.
    do_reset();
    cycle(1, 40, 5, 0, 32'h3, 0);
    cycle(1, 40, 5, 1, 32'h3, 0);
    cycle(1, 40, 5, 0, 32'h3, 0);
    chk("t5_rbid", release_barrier_id, 40);
    chk("t5_rmask", release_warp_mask, 32'h3);
    chk("t5_stall", stall_warp_mask, 32'h3);
    cycle(0, 0, 0, 0, 0, 1);
    chk("t5_gen2", stall_warp_mask, 32'h1);

    // Reset drops open barriers and a pending release.
    cycle(1, 50, 6, 0, 32'h3, 0);
    cycle(1, 52, 6, 2, 32'h4, 0);
    do_reset();
    chk_reset("t6");

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      int k;
      logic [5:0]  w;
      logic [31:0] e;
      k = $urandom_range(2);
      w = ($urandom_range(15) == 0) ? 6'd40 : 6'($urandom_range(7));
      e = ($urandom_range(7) == 0) ? ($urandom & 32'hFF) : key_exp[k];
      cycle($urandom_range(9) < 7, 16'(100 + k), 10'($urandom_range(1)),
            w, e, $urandom_range(1) == 1);
      if (n % 250 == 249) begin
        do_reset();
        chk_reset("rand_rst");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
